// File: rtl/stall_ctrl_pkg.sv
// stall_ctrl_pkg
//   Shared definitions for the pipeline hazard / stall controller:
//   Tuse/Tnew encodings, default multiply/divide busy lengths and the
//   hard-wired zero register index.
package stall_ctrl_pkg;

  // Tuse: cycles from D until the operand is consumed. TUSE_NONE means the
  // operand is not read at all; since Tnew never exceeds 2 it cannot stall.
  localparam logic [1:0] TUSE_0    = 2'd0;
  localparam logic [1:0] TUSE_1    = 2'd1;
  localparam logic [1:0] TUSE_2    = 2'd2;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // Tnew: cycles until an in-flight producer's result can be forwarded.
  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // Busy cycles of the multiply/divide unit after a start.
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // $zero is never a real dependency.
  localparam logic [4:0] ZERO = 5'd0;

endpackage

// File: rtl/stall_ctrl_md_busy_counter.sv
// md_busy_counter
//   Tracks the busy window of the multiply/divide unit with a down-counter.
//   A start loads DIV_CYCLES or MULT_CYCLES (start wins over decrement, so a
//   start while busy reloads). The counter then decrements to 0 and holds.
// Ports:
//   clk     in  clock
//   reset   in  synchronous, active-high; clears the counter
//   start   in  mult/div issuing this cycle
//   is_div  in  1 = div/divu, 0 = mult/multu (qualified by start)
//   busy    out counter nonzero
module md_busy_counter
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (start) begin
      cnt_nxt = is_div ? DIV_LD : MULT_LD;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/stall_ctrl.sv
// stall_ctrl
//   Hazard and stall controller for the five-stage MIPS core. Each cycle it
//   decides, combinationally, whether PC and IF/ID hold and whether a bubble
//   enters ID/EX. RAW hazards are found by comparing the D-stage sources
//   against E/M destinations with Tuse/Tnew timing; HI/LO users wait in D
//   while the multiply/divide unit is starting or busy.
//
//   Optional feature macro STALL_STATS_EN adds two 32-bit performance
//   counters (total stall cycles and mult/div stall cycles).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   d_rs, d_rt                 D-stage source register addresses
//   d_tuse_rs, d_tuse_rt       Tuse per source (3 = not read)
//   d_is_md                    D instruction uses the mult/div unit or HI/LO
//   e_wa, e_tnew               E-stage destination (0 = none) and Tnew
//   m_wa, m_tnew               M-stage destination (0 = none) and Tnew
//   e_md_start, e_md_is_div    mult/div issuing in E, and its kind
//   stall_pc, stall_fd         hold PC / IF/ID
//   flush_de                   clear ID/EX
//   md_busy                    mult/div busy counter nonzero
//   stall_cycles               (STALL_STATS_EN) cycles with any stall
//   md_stall_cycles            (STALL_STATS_EN) cycles with a mult/div stall
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_is_div,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        flush_de,
  output logic        md_busy
`ifdef STALL_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] md_stall_cycles
`endif
);

  logic busy_raw;
  logic rs_hit_e;
  logic rs_hit_m;
  logic rt_hit_e;
  logic rt_hit_m;
  logic stall_rs;
  logic stall_rt;
  logic stall_md;
  logic stall;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_counter (
    .clk    (clk),
    .reset  (reset),
    .start  (e_md_start),
    .is_div (e_md_is_div),
    .busy   (busy_raw)
  );

  // A producer only stalls the consumer if its result arrives later than
  // the consumer needs it. Bubbles carry wa = 0, so RAW stalls resolve as
  // the producer advances with no state of their own.
  assign rs_hit_e = (d_rs == e_wa) && (e_tnew > d_tuse_rs);
  assign rs_hit_m = (d_rs == m_wa) && (m_tnew > d_tuse_rs);
  assign rt_hit_e = (d_rt == e_wa) && (e_tnew > d_tuse_rt);
  assign rt_hit_m = (d_rt == m_wa) && (m_tnew > d_tuse_rt);

  assign stall_rs = (d_rs != ZERO) && (rs_hit_e || rs_hit_m);
  assign stall_rt = (d_rt != ZERO) && (rt_hit_e || rt_hit_m);

  // The start cycle itself counts as busy for a waiting HI/LO user, since
  // the counter is only loaded at the end of that cycle.
  assign stall_md = d_is_md && (e_md_start || busy_raw);

  assign stall = stall_rs || stall_rt || stall_md;

  // All outputs are forced low while reset is asserted.
  assign stall_pc = stall && !reset;
  assign stall_fd = stall && !reset;
  assign flush_de = stall && !reset;
  assign md_busy  = busy_raw && !reset;

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] md_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (stall_md) begin
        md_stall_cnt <= md_stall_cnt + 32'd1;
      end
    end
  end

  assign stall_cycles    = reset ? 32'd0 : stall_cnt;
  assign md_stall_cycles = reset ? 32'd0 : md_stall_cnt;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
module tb_stall_ctrl;
  import stall_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, e_wa, m_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, e_md_start, e_md_is_div;
  logic        stall_pc, stall_fd, flush_de, md_busy;
`ifdef STALL_STATS_EN
  logic [31:0] stall_cycles, md_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] val;   // {stall_pc, stall_fd, flush_de, md_busy}
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  stall_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_is_md     (d_is_md),
    .e_wa        (e_wa),
    .e_tnew      (e_tnew),
    .m_wa        (m_wa),
    .m_tnew      (m_tnew),
    .e_md_start  (e_md_start),
    .e_md_is_div (e_md_is_div),
    .stall_pc    (stall_pc),
    .stall_fd    (stall_fd),
    .flush_de    (flush_de),
    .md_busy     (md_busy)
`ifdef STALL_STATS_EN
    ,
    .stall_cycles    (stall_cycles),
    .md_stall_cycles (md_stall_cycles)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    d_rs = 5'd0; d_rt = 5'd0;
    d_tuse_rs = TUSE_NONE; d_tuse_rt = TUSE_NONE;
    d_is_md = 1'b0;
    e_wa = 5'd0; e_tnew = TNEW_0;
    m_wa = 5'd0; m_tnew = TNEW_0;
    e_md_start = 1'b0; e_md_is_div = 1'b0;
  endtask

  // Inputs for this cycle are already driven; push the expectation, compare
  // at the falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic exp_stall, input logic exp_busy);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.val = {exp_stall, exp_stall, exp_stall, exp_busy};
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check(got.tag, {28'd0, stall_pc, stall_fd, flush_de, md_busy}, {28'd0, got.val});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Reset with md activity requested: everything forced low.
    d_is_md = 1'b1; e_md_start = 1'b1;
    step("rst_c0", 1'b0, 1'b0);
    step("rst_c1", 1'b0, 1'b0);
`ifdef STALL_STATS_EN
    @(negedge clk);
    check("rst_stats_total", stall_cycles, 32'd0);
    check("rst_stats_md", md_stall_cycles, 32'd0);
    @(posedge clk); #1;
`endif
    reset = 1'b0;
    idle();
    step("post_rst_idle", 1'b0, 1'b0);

    // RAW on rs from a load in E.
    d_rs = 5'd8; d_tuse_rs = TUSE_1; e_wa = 5'd8; e_tnew = TNEW_2;
    step("raw_e_rs", 1'b1, 1'b0);
    idle();
    d_rs = 5'd0; d_tuse_rs = TUSE_1; e_wa = 5'd0; e_tnew = TNEW_2;
    step("raw_zero_reg", 1'b0, 1'b0);
    idle();
    d_rs = 5'd8; d_tuse_rs = TUSE_1; e_wa = 5'd8; e_tnew = TNEW_1;
    step("raw_tnew_eq_tuse", 1'b0, 1'b0);

    // RAW on rt from M.
    idle();
    d_rt = 5'd9; d_tuse_rt = TUSE_0; m_wa = 5'd9; m_tnew = TNEW_1;
    step("raw_m_rt", 1'b1, 1'b0);
    d_tuse_rt = TUSE_NONE;
    step("raw_m_rt_unread", 1'b0, 1'b0);

    // RAW on rt from E.
    idle();
    d_rt = 5'd5; d_tuse_rt = TUSE_0; e_wa = 5'd5; e_tnew = TNEW_1;
    step("raw_e_rt", 1'b1, 1'b0);
    // Mismatched register: no stall.
    d_rt = 5'd6;
    step("raw_no_match", 1'b0, 1'b0);

    // mult window with a HI/LO user waiting in D.
    idle();
    d_is_md = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b0;
    step("mult_c0", 1'b1, 1'b0);
    e_md_start = 1'b0;
    for (int i = 1; i <= 5; i++) step($sformatf("mult_c%0d", i), 1'b1, 1'b1);
    step("mult_c6", 1'b0, 1'b0);
`ifdef STALL_STATS_EN
    @(negedge clk);
    check("stats_total", stall_cycles, 32'd9);
    check("stats_md", md_stall_cycles, 32'd6);
    @(posedge clk); #1;
`endif

    // div, then reset in cycle 4 abandons the window.
    idle();
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    step("div_c0", 1'b0, 1'b0);
    e_md_start = 1'b0;
    for (int i = 1; i <= 3; i++) step($sformatf("div_c%0d", i), 1'b0, 1'b1);
    reset = 1'b1;
    step("div_rst_c4", 1'b0, 1'b0);
    reset = 1'b0;
    step("div_after_rst_c5", 1'b0, 1'b0);
`ifdef STALL_STATS_EN
    @(negedge clk);
    check("stats_total_cleared", stall_cycles, 32'd0);
    check("stats_md_cleared", md_stall_cycles, 32'd0);
    @(posedge clk); #1;
`endif

    // div restarted in cycle 3: busy through cycle 13.
    e_md_start = 1'b1; e_md_is_div = 1'b1;
    step("div2_c0", 1'b0, 1'b0);
    e_md_start = 1'b0;
    step("div2_c1", 1'b0, 1'b1);
    step("div2_c2", 1'b0, 1'b1);
    e_md_start = 1'b1;
    step("div2_c3_restart", 1'b0, 1'b1);
    e_md_start = 1'b0;
    for (int i = 4; i <= 13; i++) step($sformatf("div2_c%0d", i), 1'b0, 1'b1);
    step("div2_c14", 1'b0, 1'b0);
    step("div2_c15_hold0", 1'b0, 1'b0);

    // RAW and md stall at once: a single stall.
    e_md_start = 1'b1; e_md_is_div = 1'b0; d_is_md = 1'b1;
    d_rs = 5'd3; d_tuse_rs = TUSE_0; m_wa = 5'd3; m_tnew = TNEW_1;
    step("rs_and_md", 1'b1, 1'b0);
    idle();
    step("after_combo_busy", 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
